// File: rtl/pe_mac_systolic.sv
// Systolic-array MAC processing element: forwards operands east/south and
// accumulates framed dot products, with optional signed mode and saturation.
module pe_mac_systolic #(
  parameter int unsigned BW       = 8,
  parameter int unsigned ACC_BW   = 32,
  parameter bit          SIGNED   = 1'b1,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_first,
  input  logic              i_last,
  input  logic [BW-1:0]     i_activation,
  input  logic [BW-1:0]     i_weight,
  output logic [BW-1:0]     o_activation,
  output logic [BW-1:0]     o_weight,
  output logic              o_valid_fwd,
  output logic              o_first_fwd,
  output logic              o_last_fwd,
  output logic [ACC_BW-1:0] o_output,
  output logic              o_out_valid,
  output logic              o_overflow
);

  localparam int unsigned PW = 2 * BW;

  logic [PW-1:0]     a_ext, w_ext, prod_d, p_q;
  logic              s1_valid_q, s1_first_q, s1_last_q;
  logic [ACC_BW-1:0] acc_q, acc_d, base, ext_p, sum, sat_val;
  logic [ACC_BW:0]   sum_w;
  logic              sticky_q, sticky_d, ovf;

  // Operands are widened first so the low PW bits of the product are exact.
  always_comb begin
    a_ext  = SIGNED ? PW'($signed(i_activation)) : PW'(i_activation);
    w_ext  = SIGNED ? PW'($signed(i_weight))     : PW'(i_weight);
    prod_d = a_ext * w_ext;
  end

  always_comb begin
    ext_p    = SIGNED ? ACC_BW'($signed(p_q)) : ACC_BW'(p_q);
    base     = s1_first_q ? '0 : acc_q;
    sum_w    = {1'b0, base} + {1'b0, ext_p};
    sum      = sum_w[ACC_BW-1:0];
    ovf      = SIGNED ? ((base[ACC_BW-1] == ext_p[ACC_BW-1]) &&
                         (sum[ACC_BW-1] != base[ACC_BW-1]))
                      : sum_w[ACC_BW];
    // Signed overflow direction follows the sign shared by both addends.
    sat_val  = '1;
    if (SIGNED) begin
      sat_val = base[ACC_BW-1] ? {1'b1, {(ACC_BW-1){1'b0}}}
                               : {1'b0, {(ACC_BW-1){1'b1}}};
    end
    acc_d    = (ovf && SATURATE) ? sat_val : sum;
    sticky_d = (s1_first_q ? 1'b0 : sticky_q) | ovf;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_activation <= '0;
      o_weight     <= '0;
      o_valid_fwd  <= 1'b0;
      o_first_fwd  <= 1'b0;
      o_last_fwd   <= 1'b0;
      p_q          <= '0;
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      o_output     <= '0;
      o_out_valid  <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_activation <= i_activation;
      o_weight     <= i_weight;
      o_valid_fwd  <= i_valid;
      o_first_fwd  <= i_first;
      o_last_fwd   <= i_last;
      p_q          <= prod_d;
      s1_valid_q   <= i_valid;
      s1_first_q   <= i_first;
      s1_last_q    <= i_last;
      o_out_valid  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        acc_q    <= acc_d;
        sticky_q <= sticky_d;
        if (s1_last_q) begin
          o_output   <= acc_d;
          o_overflow <= sticky_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_systolic.sv
// Directed bench for pe_mac_systolic: four parameterisations share one stimulus
// stream; an arithmetic reference model feeds per-instance result queues.
module tb_pe_mac_systolic;

  logic       clk = 1'b0;
  logic       rst, v, f, l;
  logic [7:0] a, w;

  logic [31:0] out_w [4];
  logic        ov_w [4], ovl_w [4];
  logic [7:0]  fa [4], fw [4];
  logic        fv [4], ff [4], fl [4];
  logic [31:0] o0;
  logic [15:0] o1, o2, o3;

  always #5 clk = ~clk;

  pe_mac_systolic u0 (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .i_first(f), .i_last(l),
    .i_activation(a), .i_weight(w), .o_activation(fa[0]), .o_weight(fw[0]),
    .o_valid_fwd(fv[0]), .o_first_fwd(ff[0]), .o_last_fwd(fl[0]),
    .o_output(o0), .o_out_valid(ovl_w[0]), .o_overflow(ov_w[0]));

  pe_mac_systolic #(.ACC_BW(16), .SIGNED(1'b1), .SATURATE(1'b1)) u1 (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .i_first(f), .i_last(l),
    .i_activation(a), .i_weight(w), .o_activation(fa[1]), .o_weight(fw[1]),
    .o_valid_fwd(fv[1]), .o_first_fwd(ff[1]), .o_last_fwd(fl[1]),
    .o_output(o1), .o_out_valid(ovl_w[1]), .o_overflow(ov_w[1]));

  pe_mac_systolic #(.ACC_BW(16), .SIGNED(1'b1), .SATURATE(1'b0)) u2 (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .i_first(f), .i_last(l),
    .i_activation(a), .i_weight(w), .o_activation(fa[2]), .o_weight(fw[2]),
    .o_valid_fwd(fv[2]), .o_first_fwd(ff[2]), .o_last_fwd(fl[2]),
    .o_output(o2), .o_out_valid(ovl_w[2]), .o_overflow(ov_w[2]));

  pe_mac_systolic #(.ACC_BW(16), .SIGNED(1'b0), .SATURATE(1'b1)) u3 (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .i_first(f), .i_last(l),
    .i_activation(a), .i_weight(w), .o_activation(fa[3]), .o_weight(fw[3]),
    .o_valid_fwd(fv[3]), .o_first_fwd(ff[3]), .o_last_fwd(fl[3]),
    .o_output(o3), .o_out_valid(ovl_w[3]), .o_overflow(ov_w[3]));

  assign out_w[0] = o0;
  assign out_w[1] = {16'd0, o1};
  assign out_w[2] = {16'd0, o2};
  assign out_w[3] = {16'd0, o3};

  typedef struct {
    logic [31:0] val;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sb [4][$];
  int unsigned WID [4] = '{32, 16, 16, 16};
  bit          SG  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit          ST  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  longint      acc [4];
  bit          sticky [4];
  logic [31:0] held [4];
  logic        held_ovf [4];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        last_rst;
  logic        last_v, last_f, last_l;
  logic [7:0]  last_a, last_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model in integer arithmetic: range test, then clamp or wrap.
  task automatic model_elem(input int i, input logic [7:0] aa, input logic [7:0] ww,
                            input bit fi, input bit la);
    longint p, s, md, mx, mn;
    bit o;
    exp_t e;
    md = longint'(1) << WID[i];
    p  = SG[i] ? longint'($signed(aa)) * longint'($signed(ww))
               : longint'(aa) * longint'(ww);
    if (fi) begin
      acc[i] = p;
      sticky[i] = 1'b0;
    end else begin
      s = acc[i] + p;
      o = 1'b0;
      mx = SG[i] ? md / 2 - 1 : md - 1;
      mn = SG[i] ? -(md / 2) : 0;
      if (s > mx) begin
        o = 1'b1;
        s = ST[i] ? mx : s - md;
      end else if (s < mn) begin
        o = 1'b1;
        s = ST[i] ? mn : s + md;
      end
      acc[i] = s;
      sticky[i] = sticky[i] | o;
    end
    if (la) begin
      e.val = 32'(acc[i] & (md - 1));
      e.ovf = sticky[i];
      e.due = cyc + 2;
      sb[i].push_back(e);
    end
  endtask

  task automatic monitor();
    for (int i = 0; i < 4; i++) begin
      if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
        check($sformatf("pulse%0d", i), {31'd0, ovl_w[i]}, 32'd1);
        check($sformatf("out%0d", i), out_w[i], sb[i][0].val);
        check($sformatf("ovf%0d", i), {31'd0, ov_w[i]}, {31'd0, sb[i][0].ovf});
        held[i] = sb[i][0].val;
        held_ovf[i] = sb[i][0].ovf;
        void'(sb[i].pop_front());
      end else begin
        check($sformatf("nopulse%0d", i), {31'd0, ovl_w[i]}, 32'd0);
        check($sformatf("hold_out%0d", i), out_w[i], held[i]);
        check($sformatf("hold_ovf%0d", i), {31'd0, ov_w[i]}, {31'd0, held_ovf[i]});
      end
      check($sformatf("fwd_a%0d", i), {24'd0, fa[i]}, last_rst ? 32'd0 : {24'd0, last_a});
      check($sformatf("fwd_w%0d", i), {24'd0, fw[i]}, last_rst ? 32'd0 : {24'd0, last_w});
      check($sformatf("fwd_ctl%0d", i), {29'd0, fv[i], ff[i], fl[i]},
            last_rst ? 32'd0 : {29'd0, last_v, last_f, last_l});
    end
  endtask

  task automatic step(input bit r, input bit vv, input bit fi, input bit la,
                      input logic [7:0] aa, input logic [7:0] ww);
    rst = r; v = vv; f = fi; l = la; a = aa; w = ww;
    last_rst = r; last_v = vv; last_f = fi; last_l = la; last_a = aa; last_w = ww;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        acc[i] = 0;
        sticky[i] = 1'b0;
        held[i] = '0;
        held_ovf[i] = 1'b0;
        sb[i].delete();
      end else if (vv) begin
        model_elem(i, aa, ww, fi, la);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  // Bubbles carry first/last high to confirm they are ignored without valid.
  task automatic bubble();
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h5A);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 8'd3);
    bubble(); bubble();

    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd3);
    bubble();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFC, 8'd5);
    bubble(); bubble();
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 8'hFF);
    bubble(); bubble();

    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd127, 8'd127);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd127, 8'd127);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd127, 8'd127);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 8'd1);
    bubble(); bubble();

    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd255, 8'd255);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd255, 8'd255);
    bubble(); bubble();

    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd3);
    bubble(); bubble();
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd5);
    bubble(); bubble();

    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 8'd3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd9, 8'd9);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1);
    bubble(); bubble(); bubble();

    for (int i = 0; i < 4; i++) begin
      check($sformatf("drained%0d", i), 32'(sb[i].size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
